csd_mult: RTL and testbench
===========================

Name: csd_mult

Overview:
- Downstream consumer of the binary-to-CSD converter (convASD).
- After convASD signals done, the K digit memory holds a canonical-signed-digit constant. csd_mult reads that memory through its read port (reK, 4-bit digit word) and multiplies a signed 8-bit operand by the constant using MSB-first shift-add (Horner).
- It also flags illegal digit codes and CSD adjacency violations, so convASD output can be checked in-system.

Parameters:
- N_DIGITS, 16, number of CSD digits in K memory; must equal 2**ADDR_W.
- ADDR_W, 4, K memory address width.
- OP_W, 8, signed operand width.
- ACC_W, OP_W+N_DIGITS+1 (25), signed product width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a multiply; rising-edge detected.
- operand  in  OP_W  signed multiplicand; captured on the accepted start.
- addrK  out  ADDR_W  K memory read address (registered).
- reK  out  1  K memory read enable (registered).
- dataOutK  in  4  digit word from K memory; valid the cycle after a reK cycle.
- product  out  ACC_W  signed result; valid while done=1, held until next accepted start.
- busy  out  1  high from the accepted start through the FLUSH cycle.
- done  out  1  one-cycle pulse when product is final.
- err  out  1  sticky; cleared on accepted start.

Behaviour:
- Reset values: addrK=0, reK=0, product=0, busy=0, done=0, err=0, state=IDLE, start_q=0, digit counter=0.
- Start detection: start_q registers start each cycle. A start is accepted when start & ~start_q & state==IDLE. Starts in any other state are ignored and not queued.
- Digit codes:
  - 4'b0000 = 0, 4'b0001 = +1, 4'b1111 = -1.
  - Any other code is illegal, contributes 0 and sets err.
- States:
  - IDLE: on an accepted start, capture operand, clear product and err, set addrK=N_DIGITS-1 and reK=1, go to RUN.
  - RUN: lasts N_DIGITS cycles. Each cycle, addrK decrements (N_DIGITS-1 down to 0) with reK=1. From the second RUN cycle on, accumulate the digit returned for the previous address. In the last RUN cycle (addrK=0), go to FLUSH with reK=0 and addrK=0.
  - FLUSH: accumulate the digit for address 0, pulse done for one cycle, go to IDLE.
- Accumulate step: product <= (product <<< 1) + (d * sext(operand)), d in {-1,0,+1}. All arithmetic is signed ACC_W two's complement and cannot overflow for N_DIGITS<=16, OP_W<=8.
- Latency: if start is accepted at edge E0, reads are issued in the N_DIGITS cycles following E0, done is high in the cycle after edge E0+N_DIGITS+1, and busy is low in that same cycle. With defaults this is 17 clocks.
- Adjacency check: track nonzero_prev (previous digit nonzero). If the current digit and the previous digit are both nonzero, set err. nonzero_prev is cleared at start. The product is still computed normally.
- Completion: product and err stay stable after done until the next accepted start. done is never asserted together with busy.
- Restart: start held high across done does not retrigger; a fresh rising edge is required.
- Reset mid-operation: returns to IDLE immediately. reK drops asynchronously, no done pulse is generated, product=0.
- Simultaneous start and reset: reset wins.

Decomposition:
- Package csd_pkg holds:
  - the digit code localparams DIG_ZERO, DIG_POS, DIG_NEG;
  - the state encoding IDLE/RUN/FLUSH;
  - the function or constant for ACC_W.
- One combinational sub-module, csd_digit_decode:
  - input: 4-bit code;
  - outputs: nz, neg, illegal.
  - Used by csd_mult; reusable by convASD checkers.

Test Plan:
- Digits d3=+1, d0=-1, others 0 (constant 7), operand=5 -> one done pulse 17 cycles after start edge, product=35, err=0, addrK sequence 15..0 with reK high for exactly 16 cycles.
- Same memory, operand=-128 -> product=-896. Then all-zero memory, operand=127 -> product=0, err=0.
- d15=+1 only, operand=-128 -> product=-4194304 (extreme negative, no overflow). d15=-1, operand=-128 -> product=4194304.
- Code 4'b0010 at address 5, d3=+1, operand=3 -> product=24, err=1, and err stays 1 until the next start.
- Digits d4=+1, d3=-1 (adjacent nonzero), operand=1 -> product=8, err=1.
- Second start edge pulsed mid-RUN -> ignored; single result unchanged. start held high through done -> no restart.
- reset asserted at RUN cycle 6 -> reK, busy, done, product all 0 asynchronously, no done pulse. The next start then yields a correct product.

Source files
------------

// File: rtl/csd_pkg.sv
// ============================================================================
//  csd_pkg : shared digit codes, FSM states and width helper for csd_mult
//  Revision: 1.0
// ============================================================================
`default_nettype none

package csd_pkg;

   localparam logic [3:0] DIG_ZERO = 4'b0000;
   localparam logic [3:0] DIG_POS  = 4'b0001;
   localparam logic [3:0] DIG_NEG  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Product width that can never overflow for an N-digit CSD constant.
   function automatic int acc_width(input int op_w, input int n_digits);
      return op_w + n_digits + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/csd_digit_decode.sv
// ============================================================================
//  csd_digit_decode : classifies one 4-bit CSD digit code
//  Revision: 1.0
// ============================================================================
`default_nettype none

module csd_digit_decode
   import csd_pkg::*;
(
   input  logic [3:0] code,
   output logic       nz,
   output logic       neg,
   output logic       illegal
);

   assign nz      = (code == DIG_POS) || (code == DIG_NEG);
   assign neg     = (code == DIG_NEG);
   assign illegal = !(nz || (code == DIG_ZERO));

endmodule

`default_nettype wire

// File: rtl/csd_mult.sv
// ============================================================================
//  csd_mult : MSB-first shift-add multiply of a signed operand by the CSD
//             constant held in the K digit memory, with digit-legality check
//  Revision: 1.0
// ============================================================================
`default_nettype none

module csd_mult
   import csd_pkg::*;
#(
   parameter int N_DIGITS = 16,
   parameter int ADDR_W   = 4,
   parameter int OP_W     = 8,
   parameter int ACC_W    = acc_width(OP_W, N_DIGITS)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [OP_W-1:0]  operand,
   output logic [ADDR_W-1:0]       addrK,
   output logic                    reK,
   input  logic [3:0]              dataOutK,
   output logic signed [ACC_W-1:0] product,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N_DIGITS - 1);

   state_t                    r_state;
   logic                      r_start_q;
   logic [ADDR_W-1:0]         r_addr;
   logic                      r_rek;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_err;
   logic                      r_nzprev;
   logic signed [OP_W-1:0]    r_opnd;
   logic signed [ACC_W-1:0]   r_product;

   logic                      w_nz;
   logic                      w_neg;
   logic                      w_illegal;
   logic signed [ACC_W-1:0]   w_opx;
   logic signed [ACC_W-1:0]   w_term;
   logic signed [ACC_W-1:0]   w_acc;
   logic                      w_err_next;

   csd_digit_decode u_decode (
      .code    (dataOutK),
      .nz      (w_nz),
      .neg     (w_neg),
      .illegal (w_illegal)
   );

   assign w_opx = ACC_W'(r_opnd);

   always_comb begin
      w_term = '0;
      if (w_nz) begin
         w_term = w_neg ? -w_opx : w_opx;
      end
   end

   // One Horner step on the digit currently presented by the memory.
   assign w_acc      = (r_product <<< 1) + w_term;
   assign w_err_next = r_err | w_illegal | (w_nz & r_nzprev);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_start_q <= 1'b0;
         r_addr    <= '0;
         r_rek     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_nzprev  <= 1'b0;
         r_opnd    <= '0;
         r_product <= '0;
      end else begin
         r_start_q <= start;
         r_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !r_start_q) begin
                  r_opnd    <= operand;
                  r_product <= '0;
                  r_err     <= 1'b0;
                  r_nzprev  <= 1'b0;
                  r_addr    <= c_last_addr;
                  r_rek     <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= RUN;
               end
            end
            RUN: begin
               // The first RUN cycle has no returned digit yet.
               if (r_addr != c_last_addr) begin
                  r_product <= w_acc;
                  r_err     <= w_err_next;
                  r_nzprev  <= w_nz;
               end
               if (r_addr == '0) begin
                  r_rek   <= 1'b0;
                  r_state <= FLUSH;
               end else begin
                  r_addr <= r_addr - ADDR_W'(1);
               end
            end
            FLUSH: begin
               r_product <= w_acc;
               r_err     <= w_err_next;
               r_nzprev  <= w_nz;
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign addrK   = r_addr;
   assign reK     = r_rek;
   assign product = r_product;
   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_csd_mult.sv
// ============================================================================
//  tb_csd_mult : self-checking bench for csd_mult with a K memory model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csd_mult;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic signed [7:0]  operand;
   logic [3:0]         addrK;
   logic               reK;
   logic [3:0]         dataOutK = 4'd0;
   logic signed [24:0] product;
   logic               busy;
   logic               done;
   logic               err;

   logic [3:0] kmem [0:15];

   int checks = 0;
   int errors = 0;

   csd_mult dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .operand  (operand),
      .addrK    (addrK),
      .reK      (reK),
      .dataOutK (dataOutK),
      .product  (product),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Synchronous-read K memory: data valid the cycle after a reK cycle.
   always @(posedge clk) begin
      if (reK) dataOutK <= kmem[addrK];
   end

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) kmem[i] = 4'b0000;
   endtask

   // Reference: value = sum(d_i * 2^i), product = value * operand.
   task automatic model(input logic signed [7:0] op, output logic [24:0] p, output logic e);
      longint k;
      longint prod;
      int     d [0:15];
      k = 0;
      e = 1'b0;
      for (int i = 0; i < 16; i++) begin
         case (kmem[i])
            4'b0000: d[i] = 0;
            4'b0001: d[i] = 1;
            4'b1111: d[i] = -1;
            default: begin d[i] = 0; e = 1'b1; end
         endcase
         k += longint'(d[i]) * (longint'(1) << i);
      end
      for (int i = 0; i < 15; i++) begin
         if (d[i] != 0 && d[i+1] != 0) e = 1'b1;
      end
      prod = k * longint'(op);
      p = prod[24:0];
   endtask

   // Runs one multiply and records what was observed; checks happen in callers.
   task automatic run_op(input logic signed [7:0] op, input bit hold, input bit pulse_mid,
                         output logic [24:0] prod, output logic e, output int lat,
                         output int rek_cnt, output bit seq_ok, output int done_cnt,
                         output bit busy_with_done);
      int exp_addr;
      lat = -1; rek_cnt = 0; seq_ok = 1'b1; done_cnt = 0; busy_with_done = 1'b0;
      prod = '0; e = 1'b0; exp_addr = 15;
      @(negedge clk);
      operand = op;
      start   = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (reK) begin
            if (exp_addr < 0 || addrK != 4'(exp_addr)) seq_ok = 1'b0;
            rek_cnt++;
            exp_addr--;
         end
         if (done) begin
            done_cnt++;
            if (lat < 0) lat = c - 1;
            prod = product;
            e    = err;
            if (busy) busy_with_done = 1'b1;
         end
         if (!hold && c == 1) start = 1'b0;
         if (pulse_mid && c == 5) start = 1'b1;
         if (pulse_mid && c == 6) start = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; operand = '0;
      clear_mem();
      repeat (2) @(negedge clk);
      checks++;
      if ({addrK, reK, product, busy, done, err} !== 33'd0) begin
         errors++;
         $display("FAIL reset_state: addrK=%0d reK=%b product=%0d busy=%b done=%b err=%b, required all 0",
                  addrK, reK, product, busy, done, err);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [24:0] p; logic e; int lat, rc, dc; bit sq, bwd;
      clear_mem(); kmem[3] = 4'b0001; kmem[0] = 4'b1111;
      run_op(8'sd5, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd35) begin errors++; $display("FAIL basic_product: got %0d, required 35", $signed(p)); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b, required 0", e); end
      checks++; if (lat != 17) begin errors++; $display("FAIL basic_latency: got %0d, required 17", lat); end
      checks++; if (rc != 16 || !sq) begin errors++; $display("FAIL basic_reads: reK cycles %0d seq_ok %0d, required 16 and 1", rc, sq); end
      checks++; if (dc != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, required 1", dc); end
      checks++; if (bwd) begin errors++; $display("FAIL basic_busy_with_done: got 1, required 0"); end

      run_op(-8'sd128, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'(-896)) begin errors++; $display("FAIL neg_operand: got %0d, required -896", $signed(p)); end

      clear_mem();
      run_op(8'sd127, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd0 || e !== 1'b0) begin errors++; $display("FAIL zero_mem: product %0d err %b, required 0 0", $signed(p), e); end
   endtask

   task automatic test_extremes();
      logic [24:0] p; logic e; int lat, rc, dc; bit sq, bwd;
      clear_mem(); kmem[15] = 4'b0001;
      run_op(-8'sd128, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'(-4194304)) begin errors++; $display("FAIL extreme_pos_digit: got %0d, required -4194304", $signed(p)); end
      kmem[15] = 4'b1111;
      run_op(-8'sd128, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd4194304) begin errors++; $display("FAIL extreme_neg_digit: got %0d, required 4194304", $signed(p)); end
   endtask

   task automatic test_errors();
      logic [24:0] p; logic e; int lat, rc, dc; bit sq, bwd;
      clear_mem(); kmem[5] = 4'b0010; kmem[3] = 4'b0001;
      run_op(8'sd3, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd24 || e !== 1'b1) begin errors++; $display("FAIL illegal_code: product %0d err %b, required 24 1", $signed(p), e); end
      repeat (5) @(negedge clk);
      checks++; if (err !== 1'b1 || product !== 25'd24) begin errors++; $display("FAIL err_sticky: err %b product %0d, required 1 24", err, product); end

      clear_mem(); kmem[4] = 4'b0001; kmem[3] = 4'b1111;
      run_op(8'sd1, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd8 || e !== 1'b1) begin errors++; $display("FAIL adjacency: product %0d err %b, required 8 1", $signed(p), e); end

      clear_mem(); kmem[3] = 4'b0001; kmem[0] = 4'b1111;
      run_op(8'sd2, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd14 || e !== 1'b0) begin errors++; $display("FAIL err_cleared_on_start: product %0d err %b, required 14 0", $signed(p), e); end
   endtask

   task automatic test_back_to_back();
      logic [24:0] p; logic e; int lat, rc, dc; bit sq, bwd;
      clear_mem(); kmem[3] = 4'b0001; kmem[0] = 4'b1111;
      run_op(-8'sd9, 1'b0, 1'b1, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'(-63) || dc != 1 || rc != 16) begin
         errors++; $display("FAIL mid_run_start: product %0d done %0d reads %0d, required -63 1 16", $signed(p), dc, rc); end
      run_op(8'sd11, 1'b1, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd77 || dc != 1 || rc != 16) begin
         errors++; $display("FAIL held_start: product %0d done %0d reads %0d, required 77 1 16", $signed(p), dc, rc); end
   endtask

   task automatic test_reset_mid();
      logic [24:0] p; logic e; int lat, rc, dc; bit sq, bwd;
      int dcount;
      clear_mem(); kmem[3] = 4'b0001; kmem[0] = 4'b1111;
      @(negedge clk); operand = 8'sd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if ({reK, busy, done, product} !== 28'd0) begin
         errors++; $display("FAIL reset_mid_async: reK %b busy %b done %b product %0d, required all 0", reK, busy, done, product); end
      @(negedge clk); reset = 1'b0;
      dcount = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      checks++; if (dcount != 0) begin errors++; $display("FAIL reset_mid_no_done: active cycles %0d, required 0", dcount); end

      @(negedge clk); reset = 1'b1; start = 1'b1;
      @(negedge clk); reset = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_reset: busy %b, required 0", busy); end

      run_op(8'sd7, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
      checks++; if (p !== 25'd49 || lat != 17) begin
         errors++; $display("FAIL after_reset_run: product %0d latency %0d, required 49 17", $signed(p), lat); end
   endtask

   task automatic test_random();
      logic [24:0] p, ep; logic e, ee; int lat, rc, dc; bit sq, bwd;
      logic signed [7:0] op;
      int r;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 11)       kmem[i] = 4'b0000;
            else if (r < 15)  kmem[i] = 4'b0001;
            else if (r < 19)  kmem[i] = 4'b1111;
            else              kmem[i] = 4'($urandom_range(2, 14));
         end
         op = 8'($urandom);
         model(op, ep, ee);
         run_op(op, 1'b0, 1'b0, p, e, lat, rc, sq, dc, bwd);
         checks++; if (p !== ep || e !== ee || lat != 17) begin
            errors++; $display("FAIL random_%0d: product %0d err %b lat %0d, required %0d %b 17",
                               it, $signed(p), e, lat, $signed(ep), ee); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
